vector_seq_checker: RTL and testbench

VECTOR_SEQ_CHECKER -- requirements
Module: vector_seq_checker

---
 rtl/vector_seq_checker.sv | 141 ++++++++++++++
 tb/tb_vector_seq_checker.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/vector_seq_checker.sv
// Sweeps a 3-bit stimulus vector through indices 0..7 and holds each one for HOLD cycles.
// It checks the returned responses against an expected table and reports the error count and the first failing index.
module vector_seq_checker #(
    parameter int unsigned HOLD      = 4,
    parameter logic [23:0] EXP_TABLE = 24'b111_111_101_101_011_011_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       A_out,
    output logic       B_out,
    output logic       C_out,
    input  logic       X_in,
    input  logic       Y_in,
    input  logic       Z_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] fail_idx
);

    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned ERR_W = 4;
    localparam int unsigned OFF_W = 5;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(7);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [IDX_W-1:0]   abc_q, abc_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [IDX_W-1:0]   fail_q, fail_d;

    logic [OFF_W-1:0]   exp_off_c;
    logic [2:0]         exp_vec_c;
    logic               mismatch_c;
    logic               compare_c;

    // Expected response for the vector currently being driven
    always_comb begin
        exp_off_c  = OFF_W'(idx_q) * OFF_W'(3);
        exp_vec_c  = EXP_TABLE[exp_off_c +: 3];
        mismatch_c = ({X_in, Y_in, Z_in} != exp_vec_c);
        compare_c  = (state_q == DRIVE) && (hold_cnt_q == HOLD_LAST);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        hold_cnt_d = hold_cnt_q;
        err_d      = err_q;
        fail_d     = fail_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = DRIVE;
                    idx_d      = '0;
                    hold_cnt_d = '0;
                    err_d      = '0;
                    fail_d     = '0;
                end
            end
            DRIVE: begin
                if (compare_c) begin
                    if (mismatch_c) begin
                        err_d = err_q + ERR_W'(1);
                        if (err_q == '0) begin
                            fail_d = idx_q;
                        end
                    end
                    hold_cnt_d = '0;
                    // Last vector ends the sweep; idx parks at 7 instead of wrapping
                    if (idx_q == IDX_LAST) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        abc_d  = (state_d == DRIVE) ? idx_d : '0;
        busy_d = (state_d == DRIVE);
        done_d = (state_d == DONE);
        pass_d = done_d && (err_d == '0);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            hold_cnt_q <= '0;
            abc_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
            fail_q     <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            hold_cnt_q <= hold_cnt_d;
            abc_q      <= abc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_q      <= err_d;
            fail_q     <= fail_d;
        end
    end

    assign A_out     = abc_q[2];
    assign B_out     = abc_q[1];
    assign C_out     = abc_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_idx  = fail_q;

endmodule

// File: tb/tb_vector_seq_checker.sv
// Directed bench for vector_seq_checker: HOLD=4 and HOLD=1 instances driving a small combinational stage model.
module tb_vector_seq_checker;

    logic clk = 1'b0;
    logic rst;
    logic start4, start1;
    logic fault;
    logic dly;

    logic a4, b4, c4, x4, y4, z4, busy4, done4, pass4;
    logic [3:0] err4;
    logic [2:0] fidx4;
    logic a1, b1, c1, x1, y1, z1, busy1, done1, pass1;
    logic [3:0] err1;
    logic [2:0] fidx1;
    logic [2:0] resp1_q;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Stage under test: X=A, Y=B, Z=A|B (Z stuck at 0 when fault=1)
    assign x4 = a4;
    assign y4 = b4;
    assign z4 = fault ? 1'b0 : (a4 | b4);

    // HOLD=1 stage, optionally answering one cycle late
    always_ff @(posedge clk) resp1_q <= {a1, b1, a1 | b1};
    assign x1 = dly ? resp1_q[2] : a1;
    assign y1 = dly ? resp1_q[1] : b1;
    assign z1 = dly ? resp1_q[0] : (a1 | b1);

    vector_seq_checker #(.HOLD(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4),
        .A_out(a4), .B_out(b4), .C_out(c4),
        .X_in(x4), .Y_in(y4), .Z_in(z4),
        .busy(busy4), .done(done4), .pass(pass4),
        .err_count(err4), .fail_idx(fidx4)
    );

    vector_seq_checker #(.HOLD(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .A_out(a1), .B_out(b1), .C_out(c1),
        .X_in(x1), .Y_in(y1), .Z_in(z1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_idx(fidx1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] abc_of(input int sel);
        return (sel == 4) ? {a4, b4, c4} : {a1, b1, c1};
    endfunction

    function automatic logic [2:0] flags_of(input int sel);
        return (sel == 4) ? {busy4, done4, pass4} : {busy1, done1, pass1};
    endfunction

    function automatic logic [6:0] res_of(input int sel);
        return (sel == 4) ? {err4, fidx4} : {err1, fidx1};
    endfunction

    task automatic set_start(input int sel, input logic v);
        if (sel == 4) start4 = v;
        else          start1 = v;
    endtask

    // One full sweep from start pulse to the first DONE cycle
    task automatic sweep(input int sel, input int hold, input logic exp_pass,
                         input int exp_err, input int exp_fidx, input int extra_k);
        logic [2:0] fl;
        logic [6:0] rs;
        set_start(sel, 1'b1);
        tick();
        set_start(sel, 1'b0);
        for (int k = 1; k <= 8 * hold; k++) begin
            fl = flags_of(sel);
            chk("abc", 32'(abc_of(sel)), 32'((k - 1) / hold));
            chk("busy_drive", 32'(fl[2]), 32'd1);
            chk("done_drive", 32'(fl[1]), 32'd0);
            chk("pass_drive", 32'(fl[0]), 32'd0);
            if (k == 1) begin
                rs = res_of(sel);
                chk("err_clear", 32'(rs[6:3]), 32'd0);
                chk("fidx_clear", 32'(rs[2:0]), 32'd0);
            end
            set_start(sel, (k == extra_k) ? 1'b1 : 1'b0);
            tick();
        end
        set_start(sel, 1'b0);
        fl = flags_of(sel);
        rs = res_of(sel);
        chk("done_end", 32'(fl[1]), 32'd1);
        chk("busy_end", 32'(fl[2]), 32'd0);
        chk("abc_end", 32'(abc_of(sel)), 32'd0);
        chk("pass_end", 32'(fl[0]), 32'(exp_pass));
        chk("err_end", 32'(rs[6:3]), 32'(exp_err));
        chk("fidx_end", 32'(rs[2:0]), 32'(exp_fidx));
    endtask

    task automatic chk_idle(input string tag, input int sel);
        logic [6:0] rs;
        rs = res_of(sel);
        chk({tag, "_abc"}, 32'(abc_of(sel)), 32'd0);
        chk({tag, "_flags"}, 32'(flags_of(sel)), 32'd0);
        chk({tag, "_err"}, 32'(rs[6:3]), 32'd0);
        chk({tag, "_fidx"}, 32'(rs[2:0]), 32'd0);
    endtask

    initial begin
        rst    = 1'b1;
        start4 = 1'b0;
        start1 = 1'b0;
        fault  = 1'b0;
        dly    = 1'b0;
        tick();
        tick();
        chk_idle("reset4", 4);
        chk_idle("reset1", 1);
        rst = 1'b0;
        tick();

        // Correct stage: pass sweep
        sweep(4, 4, 1'b1, 0, 0, 0);

        // Z stuck at 0, with an extra start at cycle 10 that must be ignored
        fault = 1'b1;
        sweep(4, 4, 1'b0, 6, 2, 10);

        // Restart from DONE with a good stage
        fault = 1'b0;
        sweep(4, 4, 1'b1, 0, 0, 0);

        // Reset at idx=5 with faulty stage, start asserted alongside reset
        fault = 1'b1;
        set_start(4, 1'b1);
        tick();
        set_start(4, 1'b0);
        repeat (20) tick();
        chk("abc_mid", 32'(abc_of(4)), 32'd5);
        chk("err_mid", 32'(err4), 32'd3);
        rst = 1'b1;
        start4 = 1'b1;
        tick();
        rst = 1'b0;
        start4 = 1'b0;
        chk_idle("midrst", 4);
        repeat (3) tick();
        chk("no_auto_start", 32'(busy4), 32'd0);
        fault = 1'b0;
        sweep(4, 4, 1'b1, 0, 0, 0);

        // HOLD=1: correct stage, then a stage delayed by one cycle
        sweep(1, 1, 1'b1, 0, 0, 0);
        dly = 1'b1;
        sweep(1, 1, 1'b0, 3, 2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
